rprelu_param_ctrl: RTL and testbench

RPRELU_PARAM_CTRL -- requirements
Module: rprelu_param_ctrl

---
 rtl/rprelu_param_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rprelu_param_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rprelu_param_ctrl.sv
// -----------------------------------------------------------------------------
// rprelu_param_ctrl
//
// Loads the per-channel RPReLU parameters (beta, gamma, zeta) from a serial
// configuration stream into a shadow bank. Once the whole bank has arrived,
// the shadow bank is copied to the active bank in a single COMMIT cycle.
// The active bank therefore never shows a half-written parameter set. The
// block also gates the upstream batch-norm valid. Beats that arrive while
// no committed bank is available are dropped and counted.
//
// Ports
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   cfg_start      one-cycle pulse, begins a parameter load (IDLE only)
//   cfg_valid      cfg_data carries a word
//   cfg_ready      high in LOAD: a word is accepted on cfg_valid & cfg_ready
//   cfg_data       signed parameter word, order ch0 beta/gamma/zeta, ch1 ...
//   cfg_err        one-cycle pulse when cfg_start arrives during LOAD/COMMIT
//   mode_in        RPReLU stage enable
//   data_in_valid  upstream beat valid
//   act_valid      gated valid to the RPReLU datapath
//   rprelu_beta    active beta bank  [CHANNEL_NUM]
//   rprelu_gamma   active gamma bank [CHANNEL_NUM]
//   rprelu_zeta    active zeta bank  [CHANNEL_NUM]
//   param_ready    active bank holds at least one committed load
//   drop_cnt       saturating count of dropped upstream beats
// -----------------------------------------------------------------------------
module rprelu_param_ctrl #(
   parameter int PARA_WIDTH  = 16,
   parameter int CHANNEL_NUM = 128   // legal range 2..1024
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         cfg_start,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic signed [PARA_WIDTH-1:0] cfg_data,
   output logic                         cfg_err,
   input  logic                         mode_in,
   input  logic                         data_in_valid,
   output logic                         act_valid,
   output logic signed [PARA_WIDTH-1:0] rprelu_beta  [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_zeta  [CHANNEL_NUM],
   output logic                         param_ready,
   output logic [15:0]                  drop_cnt
);

   localparam int              CH_W    = $clog2(CHANNEL_NUM);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_NUM - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Field selector inside one channel, in stream order.
   typedef enum logic [1:0] {
      SEL_BETA  = 2'd0,
      SEL_GAMMA = 2'd1,
      SEL_ZETA  = 2'd2
   } sel_t;

   state_t          state;
   state_t          state_nxt;
   sel_t            sel;
   logic [CH_W-1:0] ch;

   logic            accept;     // word taken this cycle
   logic            last_word;  // word for channel CHANNEL_NUM-1, zeta
   logic            drop;

   logic signed [PARA_WIDTH-1:0] shadow_beta  [CHANNEL_NUM];
   logic signed [PARA_WIDTH-1:0] shadow_gamma [CHANNEL_NUM];
   logic signed [PARA_WIDTH-1:0] shadow_zeta  [CHANNEL_NUM];

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         // NOTE: every clocked block uses non-blocking assignments, so all
         // registers sample their inputs from the same edge and simulation
         // ordering between blocks cannot change the result.
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and control outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets its default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_nxt = state;
      cfg_ready = 1'b0;
      cfg_err   = 1'b0;
      accept    = 1'b0;
      last_word = 1'b0;

      case (state)
         IDLE: begin
            if (cfg_start) begin
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            cfg_ready = 1'b1;
            // A start request here is dropped; the load in progress goes on.
            cfg_err   = cfg_start;
            accept    = cfg_valid;
            last_word = cfg_valid && (ch == CH_LAST) && (sel == SEL_ZETA);
            if (last_word) begin
               state_nxt = COMMIT;
            end
         end

         COMMIT: begin
            cfg_err   = cfg_start;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Channel counter and field selector
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ch  <= '0;
         sel <= SEL_BETA;
      end else if ((state == IDLE) && cfg_start) begin
         ch  <= '0;
         sel <= SEL_BETA;
      end else if (accept) begin
         case (sel)
            SEL_BETA:  sel <= SEL_GAMMA;
            SEL_GAMMA: sel <= SEL_ZETA;
            default: begin
               sel <= SEL_BETA;
               ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Shadow bank: written word by word during LOAD
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the parameter banks are reset even though they are storage
         // arrays. A reset in the middle of a load must not leave a partial
         // bank that a later commit could expose.
         shadow_beta  <= '{default: '0};
         shadow_gamma <= '{default: '0};
         shadow_zeta  <= '{default: '0};
      end else if (accept) begin
         case (sel)
            SEL_BETA:  shadow_beta[ch]  <= cfg_data;
            SEL_GAMMA: shadow_gamma[ch] <= cfg_data;
            default:   shadow_zeta[ch]  <= cfg_data;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Active bank: whole-bank copy at the end of COMMIT
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rprelu_beta  <= '{default: '0};
         rprelu_gamma <= '{default: '0};
         rprelu_zeta  <= '{default: '0};
         param_ready  <= 1'b0;
      end else if (state == COMMIT) begin
         rprelu_beta  <= shadow_beta;
         rprelu_gamma <= shadow_gamma;
         rprelu_zeta  <= shadow_zeta;
         param_ready  <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Valid gating and drop counter
   // ---------------------------------------------------------------------------
   // The datapath is blocked in the COMMIT cycle because the bank is being
   // swapped there. During a reload the previous bank stays live.
   assign act_valid = data_in_valid & mode_in & param_ready & (state != COMMIT);
   assign drop      = data_in_valid & mode_in & ~act_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_rprelu_param_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rprelu_param_ctrl
//
// Directed bench for rprelu_param_ctrl with the default parameters
// (PARA_WIDTH=16, CHANNEL_NUM=128). Inputs are driven 1 time unit after the
// rising edge, and outputs are sampled 1 unit later. The bench computes all
// expected values itself from the word patterns below.
// -----------------------------------------------------------------------------
module tb_rprelu_param_ctrl;

   localparam int PW    = 16;
   localparam int CN    = 128;
   localparam int WORDS = 3 * CN;

   logic                 clk;
   logic                 rstn;
   logic                 cfg_start;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic signed [PW-1:0] cfg_data;
   logic                 cfg_err;
   logic                 mode_in;
   logic                 data_in_valid;
   logic                 act_valid;
   logic signed [PW-1:0] rprelu_beta  [CN];
   logic signed [PW-1:0] rprelu_gamma [CN];
   logic signed [PW-1:0] rprelu_zeta  [CN];
   logic                 param_ready;
   logic [15:0]          drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   rprelu_param_ctrl #(
      .PARA_WIDTH  (PW),
      .CHANNEL_NUM (CN)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cfg_start     (cfg_start),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .cfg_err       (cfg_err),
      .mode_in       (mode_in),
      .data_in_valid (data_in_valid),
      .act_valid     (act_valid),
      .rprelu_beta   (rprelu_beta),
      .rprelu_gamma  (rprelu_gamma),
      .rprelu_zeta   (rprelu_zeta),
      .param_ready   (param_ready),
      .drop_cnt      (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if something hangs (the normal run ends near 740k).
   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, want normal end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   // Word k of a load stream. Pattern 0 is the index value; pattern 1 is
   // -(k+1), so it differs from pattern 0 in every word.
   function automatic logic signed [PW-1:0] word_val(input int pat, input int k);
      if (pat == 0) return PW'(k);
      return PW'(-k - 1);
   endfunction

   // Number of active-bank entries that differ from pattern pat.
   function automatic int bank_mis(input int pat);
      int n = 0;
      for (int c = 0; c < CN; c++) begin
         if (rprelu_beta[c]  !== word_val(pat, 3*c))     n++;
         if (rprelu_gamma[c] !== word_val(pat, 3*c + 1)) n++;
         if (rprelu_zeta[c]  !== word_val(pat, 3*c + 2)) n++;
      end
      return n;
   endfunction

   // Number of nonzero active-bank entries.
   function automatic int bank_nz();
      int n = 0;
      for (int c = 0; c < CN; c++) begin
         if (rprelu_beta[c]  !== '0) n++;
         if (rprelu_gamma[c] !== '0) n++;
         if (rprelu_zeta[c]  !== '0) n++;
      end
      return n;
   endfunction

   // Runs one load from the cfg_start cycle to the COMMIT cycle. The task
   // returns 1 unit after the edge that enters COMMIT. With gaps set,
   // cfg_valid alternates 0/1 and starts with a gap. A start_at >= 0 pulses
   // cfg_start with word start_at. A rst_at >= 0 asserts rstn with word
   // rst_at and returns at once.
   task automatic load_bank(input int pat, input bit gaps, input int start_at,
                            input int rst_at, output int ld_cycles,
                            output int err_cycles, output int act_lo,
                            output bit aborted);
      int k;
      bit gap_phase;
      k          = 0;
      ld_cycles  = 0;
      err_cycles = 0;
      act_lo     = 0;
      aborted    = 1'b0;
      gap_phase  = gaps;

      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      #1;
      if (cfg_err) err_cycles++;
      if (data_in_valid && mode_in && !act_valid) act_lo++;
      @(posedge clk); #1;
      cfg_start = 1'b0;

      while (k < WORDS) begin
         if (k == rst_at) begin
            rstn      = 1'b0;
            cfg_valid = 1'b0;
            aborted   = 1'b1;
            break;
         end
         cfg_valid = !gap_phase;
         cfg_data  = word_val(pat, k);
         cfg_start = (k == start_at) && !gap_phase;
         #1;
         if (cfg_ready) ld_cycles++;
         if (cfg_err) err_cycles++;
         if (data_in_valid && mode_in && !act_valid) act_lo++;
         @(posedge clk); #1;
         if (cfg_valid) k++;
         if (gaps) gap_phase = !gap_phase;
      end
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
   endtask

   int ldc, errc, alo;
   bit abt;

   initial begin
      rstn          = 1'b0;
      cfg_start     = 1'b0;
      cfg_valid     = 1'b0;
      cfg_data      = '0;
      mode_in       = 1'b0;
      data_in_valid = 1'b0;

      // ---- reset state ----
      #3;
      check("rst_param_ready", param_ready, 0);
      check("rst_cfg_ready",   cfg_ready,   0);
      check("rst_cfg_err",     cfg_err,     0);
      check("rst_drop_cnt",    drop_cnt,    0);
      check("rst_act_valid",   act_valid,   0);
      check("rst_bank_nz",     bank_nz(),   0);
      #19 rstn = 1'b1;
      @(posedge clk); #1;

      // ---- gating before any load: 5 dropped beats ----
      data_in_valid = 1'b1;
      mode_in       = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("pre_act_valid", act_valid, 0);
         @(posedge clk); #1;
      end
      data_in_valid = 1'b0;
      #1;
      check("pre_drop_cnt", drop_cnt, 5);

      // ---- full load, pattern 0 (value = index) ----
      load_bank(0, 1'b0, -1, -1, ldc, errc, alo, abt);
      #1;
      check("a_load_cycles",       ldc,         WORDS);
      check("a_err_cycles",        errc,        0);
      check("a_commit_cfg_ready",  cfg_ready,   0);
      check("a_commit_param_rdy",  param_ready, 0);
      check("a_commit_bank_nz",    bank_nz(),   0);
      @(posedge clk); #1;
      check("a_param_ready", param_ready,     1);
      check("a_beta0",       rprelu_beta[0],  0);
      check("a_gamma0",      rprelu_gamma[0], 1);
      check("a_zeta0",       rprelu_zeta[0],  2);
      check("a_zeta127",     rprelu_zeta[127], 383);
      check("a_bank",        bank_mis(0),     0);

      // ---- gating after the load: 5 passed beats ----
      data_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("post_act_valid", act_valid, 1);
         @(posedge clk); #1;
      end
      check("post_drop_cnt", drop_cnt, 5);

      // ---- reload pattern 1 while the datapath is busy ----
      load_bank(1, 1'b0, -1, -1, ldc, errc, alo, abt);
      #1;
      check("b_act_lo_in_load",   alo,         0);
      check("b_commit_act_valid", act_valid,   0);
      check("b_commit_bank_old",  bank_mis(0), 0);
      check("b_commit_drop_cnt",  drop_cnt,    5);
      @(posedge clk); #1;
      check("b_act_valid", act_valid,       1);
      check("b_drop_cnt",  drop_cnt,        6);
      check("b_beta0",     rprelu_beta[0],  -1);
      check("b_zeta127",   rprelu_zeta[127], -384);
      check("b_bank",      bank_mis(1),     0);
      data_in_valid = 1'b0;

      // ---- backpressure: cfg_valid toggles, pattern 0 again ----
      load_bank(0, 1'b1, -1, -1, ldc, errc, alo, abt);
      #1;
      check("gap_load_cycles", ldc, 2 * WORDS);
      @(posedge clk); #1;
      check("gap_zeta127", rprelu_zeta[127], 383);
      check("gap_bank",    bank_mis(0),      0);

      // ---- cfg_start at word 100 is ignored, pattern 1 ----
      load_bank(1, 1'b0, 100, -1, ldc, errc, alo, abt);
      #1;
      check("mid_err_cycles",  errc, 1);
      check("mid_load_cycles", ldc,  WORDS);
      @(posedge clk); #1;
      check("mid_bank", bank_mis(1), 0);

      // ---- reset at word 200 aborts the load ----
      load_bank(0, 1'b0, -1, 200, ldc, errc, alo, abt);
      #1;
      check("rl_aborted",     abt,         1);
      check("rl_param_ready", param_ready, 0);
      check("rl_cfg_ready",   cfg_ready,   0);
      check("rl_drop_cnt",    drop_cnt,    0);
      check("rl_bank_nz",     bank_nz(),   0);
      @(posedge clk); #1;
      rstn      = 1'b1;
      #1;
      cfg_start = 1'b1;
      #1;
      check("rl_idle_cfg_ready", cfg_ready, 0);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      #1;
      check("rl_restart_cfg_ready", cfg_ready, 1);

      // ---- drop counter saturation (param_ready=0, so every beat drops) ----
      data_in_valid = 1'b1;
      mode_in       = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      check("sat_fffe", drop_cnt, 16'hFFFE);
      repeat (70000 - 65534) @(posedge clk);
      #1;
      check("sat_ffff", drop_cnt, 16'hFFFF);
      data_in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
